// File: rtl/serial_shift_tx.sv
// Parallel-in / serial-out transmitter: accepts one WIDTH-bit word via valid/ready,
// shifts it out one bit per clock framed by frameOut, then pulses done for one cycle.
module serial_shift_tx #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             loadValid,
   input  logic [WIDTH-1:0] loadData,
   output logic             loadReady,
   output logic             serialOut,
   output logic             frameOut,
   output logic             done
);

   localparam int CW      = $clog2(WIDTH) + 1;
   localparam bit MSB_SEL = (MSB_FIRST != 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift_reg;
   logic [CW-1:0]    r_bit_count;
   logic             r_serial;
   logic             r_frame;
   logic             r_done;

   logic             w_accept;
   logic             w_last;
   logic             w_first_bit;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_load_rest;
   logic [WIDTH-1:0] w_shift_rest;

   assign w_accept = loadValid && (r_state == S_IDLE);
   assign w_last   = (r_bit_count == CW'(WIDTH));

   // The register holds only the bits not yet presented, aligned so the next one
   // always sits at the outgoing end.
   always_comb begin
      w_first_bit  = 1'b0;
      w_next_bit   = 1'b0;
      w_load_rest  = '0;
      w_shift_rest = '0;
      if (MSB_SEL) begin
         w_first_bit  = loadData[WIDTH-1];
         w_load_rest  = {loadData[WIDTH-2:0], 1'b0};
         w_next_bit   = r_shift_reg[WIDTH-1];
         w_shift_rest = {r_shift_reg[WIDTH-2:0], 1'b0};
      end else begin
         w_first_bit  = loadData[0];
         w_load_rest  = {1'b0, loadData[WIDTH-1:1]};
         w_next_bit   = r_shift_reg[0];
         w_shift_rest = {1'b0, r_shift_reg[WIDTH-1:1]};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; the async reset branch clears outputs without waiting for a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_shift_reg <= '0;
         r_bit_count <= '0;
         r_serial    <= 1'b0;
         r_frame     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shift_reg <= w_load_rest;
                  r_serial    <= w_first_bit;
                  r_frame     <= 1'b1;
                  r_bit_count <= CW'(1);
                  r_state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_last) begin
                  r_serial <= 1'b0;
                  r_frame  <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_serial    <= w_next_bit;
                  r_shift_reg <= w_shift_rest;
                  r_bit_count <= r_bit_count + CW'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign loadReady = (r_state == S_IDLE);
   assign serialOut = r_serial;
   assign frameOut  = r_frame;
   assign done      = r_done;

endmodule
